// File: rtl/operand_fetch_pkg.sv
// Shared CPU constants and types for the operand-fetch stage.
// srcMatch is the single definition of "this writer produces the register I read".
package operand_fetch_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int UOP_W  = 32;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use1;
        logic              use2;
        logic [REG_AW-1:0] rd;
        logic              rdWe;
        logic [UOP_W-1:0]  uop;
    } stage_t;

    // r0 is never a bypass target, whatever a writer claims.
    function automatic logic srcMatch(input logic              v,
                                      input logic              we,
                                      input logic [REG_AW-1:0] waddr,
                                      input logic [REG_AW-1:0] rs);
        return v & we & (waddr == rs) & (rs != '0);
    endfunction

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// One source operand: picks exe > mem > wb > register file, forces r0 to zero,
// and flags when the producing value is not yet available.
module fwd_mux
    import operand_fetch_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_use,
    input  logic [XLEN-1:0]   i_rdata,
    input  logic              i_exeValid,
    input  logic              i_exeWe,
    input  logic              i_exeIsLoad,
    input  logic [REG_AW-1:0] i_exeWaddr,
    input  logic [XLEN-1:0]   i_exeWdata,
    input  logic              i_memValid,
    input  logic              i_memWe,
    input  logic              i_memReady,
    input  logic [REG_AW-1:0] i_memWaddr,
    input  logic [XLEN-1:0]   i_memWdata,
    input  logic              i_wbWe,
    input  logic [REG_AW-1:0] i_wbWaddr,
    input  logic [XLEN-1:0]   i_wbWdata,
    output logic [XLEN-1:0]   o_value,
    output logic              o_notReady
);

    logic w_exeHit;
    logic w_memHit;
    logic w_wbHit;

    assign w_exeHit = srcMatch(i_exeValid, i_exeWe, i_exeWaddr, i_rs);
    assign w_memHit = srcMatch(i_memValid, i_memWe, i_memWaddr, i_rs);
    assign w_wbHit  = srcMatch(1'b1, i_wbWe, i_wbWaddr, i_rs);

    always_comb begin
        o_value = i_rdata;
        if (i_rs == '0)
            o_value = '0;
        else if (w_exeHit)
            o_value = i_exeWdata;
        else if (w_memHit)
            o_value = i_memWdata;
        else if (w_wbHit)
            o_value = i_wbWdata;
    end

    // A load still in exe, or a mem stage that has not finished, cannot forward yet.
    assign o_notReady = i_use & ((w_exeHit & i_exeIsLoad) | (w_memHit & ~i_memReady));

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch pipeline stage: holds one decoded instruction, reads the register
// file and resolves bypasses, stalling on load-use or an unfinished mem stage.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [UOP_W-1:0]  in_uop,
    output logic [REG_AW-1:0] raddr1,
    input  logic [XLEN-1:0]   rdata1,
    output logic [REG_AW-1:0] raddr2,
    input  logic [XLEN-1:0]   rdata2,
    input  logic              exe_valid,
    input  logic              exe_we,
    input  logic              exe_is_load,
    input  logic [REG_AW-1:0] exe_waddr,
    input  logic [XLEN-1:0]   exe_wdata,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic              mem_ready,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [XLEN-1:0]   wb_wdata,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_src1,
    output logic [XLEN-1:0]   out_src2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic [UOP_W-1:0]  out_uop,
    input  logic              flush
);

    logic   r_valid;
    stage_t r_stage;
    logic   w_notReady1;
    logic   w_notReady2;
    logic   w_readyGo;
    logic   w_load;

    assign w_readyGo  = ~(w_notReady1 | w_notReady2);
    assign in_allowin = ~r_valid | (w_readyGo & out_allowin);
    assign w_load     = in_valid & in_allowin & ~flush;

    // Payload only moves on a load, so stalls and back-pressure keep it frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_stage <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid       <= 1'b1;
            r_stage.pc    <= in_pc;
            r_stage.rs1   <= in_rs1;
            r_stage.rs2   <= in_rs2;
            r_stage.use1  <= in_use1;
            r_stage.use2  <= in_use2;
            r_stage.rd    <= in_rd;
            r_stage.rdWe  <= in_rd_we;
            r_stage.uop   <= in_uop;
        end else if (r_valid & w_readyGo & out_allowin) begin
            r_valid <= 1'b0;
        end
    end

    assign raddr1 = r_stage.rs1;
    assign raddr2 = r_stage.rs2;

    fwd_mux u_fwdSrc1 (
        .i_rs        (r_stage.rs1),
        .i_use       (r_stage.use1),
        .i_rdata     (rdata1),
        .i_exeValid  (exe_valid),
        .i_exeWe     (exe_we),
        .i_exeIsLoad (exe_is_load),
        .i_exeWaddr  (exe_waddr),
        .i_exeWdata  (exe_wdata),
        .i_memValid  (mem_valid),
        .i_memWe     (mem_we),
        .i_memReady  (mem_ready),
        .i_memWaddr  (mem_waddr),
        .i_memWdata  (mem_wdata),
        .i_wbWe      (wb_we),
        .i_wbWaddr   (wb_waddr),
        .i_wbWdata   (wb_wdata),
        .o_value     (out_src1),
        .o_notReady  (w_notReady1)
    );

    fwd_mux u_fwdSrc2 (
        .i_rs        (r_stage.rs2),
        .i_use       (r_stage.use2),
        .i_rdata     (rdata2),
        .i_exeValid  (exe_valid),
        .i_exeWe     (exe_we),
        .i_exeIsLoad (exe_is_load),
        .i_exeWaddr  (exe_waddr),
        .i_exeWdata  (exe_wdata),
        .i_memValid  (mem_valid),
        .i_memWe     (mem_we),
        .i_memReady  (mem_ready),
        .i_memWaddr  (mem_waddr),
        .i_memWdata  (mem_wdata),
        .i_wbWe      (wb_we),
        .i_wbWaddr   (wb_waddr),
        .i_wbWdata   (wb_wdata),
        .o_value     (out_src2),
        .o_notReady  (w_notReady2)
    );

    // A reset edge discards the held instruction just like a flush.
    assign out_valid = r_valid & w_readyGo & ~flush & ~reset;
    assign out_pc    = r_stage.pc;
    assign out_rd    = r_stage.rd;
    assign out_rd_we = r_stage.rdWe;
    assign out_uop   = r_stage.uop;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: expected outputs are queued when an
// instruction is issued and compared when the stage presents it downstream.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_allowin;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_use1;
    logic        in_use2;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [31:0] in_uop;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        exe_valid;
    logic        exe_we;
    logic        exe_is_load;
    logic [4:0]  exe_waddr;
    logic [31:0] exe_wdata;
    logic        mem_valid;
    logic        mem_we;
    logic        mem_ready;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        out_valid;
    logic        out_allowin;
    logic [31:0] out_pc;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_uop;
    logic        flush;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  rd;
        logic        rdWe;
        logic [31:0] uop;
    } exp_t;

    exp_t        scoreboard[$];
    logic [31:0] regs [32];
    int          compareCount = 0;
    int          mismatchCount = 0;
    int          waited;

    operand_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_allowin  (in_allowin),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_use1     (in_use1),
        .in_use2     (in_use2),
        .in_rd       (in_rd),
        .in_rd_we    (in_rd_we),
        .in_uop      (in_uop),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .raddr2      (raddr2),
        .rdata2      (rdata2),
        .exe_valid   (exe_valid),
        .exe_we      (exe_we),
        .exe_is_load (exe_is_load),
        .exe_waddr   (exe_waddr),
        .exe_wdata   (exe_wdata),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .out_valid   (out_valid),
        .out_allowin (out_allowin),
        .out_pc      (out_pc),
        .out_src1    (out_src1),
        .out_src2    (out_src2),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_uop     (out_uop),
        .flush       (flush)
    );

    // Register file model: asynchronous read, r0 hardwired to zero.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearBypass();
        exe_valid = 0; exe_we = 0; exe_is_load = 0; exe_waddr = 0; exe_wdata = 0;
        mem_valid = 0; mem_we = 0; mem_ready = 1; mem_waddr = 0; mem_wdata = 0;
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    endtask

    task automatic driveInstr(input logic [31:0] pc, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic use1, input logic use2,
                              input logic [31:0] uop);
        in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
        in_use1 = use1; in_use2 = use2; in_rd = pc[6:2]; in_rd_we = 1; in_uop = uop;
    endtask

    task automatic pushExpected(input logic [31:0] pc, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] uop);
        exp_t e;
        e.pc = pc; e.src1 = e1; e.src2 = e2; e.rd = pc[6:2]; e.rdWe = 1; e.uop = uop;
        scoreboard.push_back(e);
    endtask

    // Called at posedge+1; waits (bounded) for out_valid at the negedge, then compares.
    task automatic popCompare(input string tag, output int cycles);
        exp_t e;
        cycles = 0;
        #4;
        while (!out_valid && cycles < 10) begin
            nextCycle();
            #4;
            cycles++;
        end
        if (!out_valid) begin
            checkOutput({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
            if (scoreboard.size() > 0) void'(scoreboard.pop_front());
        end else if (scoreboard.size() == 0) begin
            checkOutput({tag, "_unexpected"}, scoreboard.size(), 32'd1);
        end else begin
            e = scoreboard.pop_front();
            checkOutput({tag, "_pc"},   out_pc,   e.pc);
            checkOutput({tag, "_src1"}, out_src1, e.src1);
            checkOutput({tag, "_src2"}, out_src2, e.src2);
            checkOutput({tag, "_rd"},   {27'd0, out_rd}, {27'd0, e.rd});
            checkOutput({tag, "_rdWe"}, {31'd0, out_rd_we}, {31'd0, e.rdWe});
            checkOutput({tag, "_uop"},  out_uop,  e.uop);
        end
    endtask

    // Issue one instruction at posedge+1 under the current bypass settings.
    task automatic applyStimulus(input string tag, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use1, input logic use2, input logic [31:0] uop,
                                 input logic [31:0] e1, input logic [31:0] e2,
                                 output int cycles);
        driveInstr(pc, rs1, rs2, use1, use2, uop);
        #4;
        checkOutput({tag, "_allowin"}, {31'd0, in_allowin}, 32'd1);
        nextCycle();
        in_valid = 0;
        pushExpected(pc, e1, e2, uop);
        popCompare(tag, cycles);
        nextCycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0100_0000 + i;
        regs[5] = 32'h1111_1111;
        reset = 1; flush = 0; out_allowin = 1;
        in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_use1 = 0; in_use2 = 0;
        in_rd = 0; in_rd_we = 0; in_uop = 0;
        clearBypass();

        nextCycle();
        nextCycle();
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstOutPc",    out_pc, 32'd0);
        checkOutput("rstSrc1",     out_src1, 32'd0);
        checkOutput("rstUop",      out_uop, 32'd0);
        checkOutput("rstRaddr",    {22'd0, raddr1, raddr2}, 32'd0);
        checkOutput("rstAllowin",  {31'd0, in_allowin}, 32'd1);
        reset = 0;

        applyStimulus("rfRead", 32'h100, 5'd5, 5'd9, 1, 1, 32'hDEAD0001,
                      32'h1111_1111, 32'h0100_0009, waited);
        checkOutput("rfReadLatency", waited, 32'd0);

        exe_valid = 1; exe_we = 1; exe_waddr = 5; exe_wdata = 32'hAAAA_0000;
        mem_valid = 1; mem_we = 1; mem_waddr = 5; mem_wdata = 32'hBBBB_0000;
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'hCCCC_0000;
        applyStimulus("fwdExe", 32'h104, 5'd5, 5'd0, 1, 0, 32'hDEAD0002,
                      32'hAAAA_0000, 32'd0, waited);
        exe_valid = 0;
        applyStimulus("fwdMem", 32'h108, 5'd5, 5'd0, 1, 0, 32'hDEAD0003,
                      32'hBBBB_0000, 32'd0, waited);
        mem_valid = 0;
        applyStimulus("fwdWb", 32'h10C, 5'd5, 5'd5, 1, 1, 32'hDEAD0004,
                      32'hCCCC_0000, 32'hCCCC_0000, waited);
        clearBypass();

        exe_valid = 1; exe_we = 1; exe_is_load = 1; exe_waddr = 0; exe_wdata = 32'hFFFF_FFFF;
        applyStimulus("r0Zero", 32'h110, 5'd0, 5'd0, 1, 1, 32'hDEAD0005,
                      32'd0, 32'd0, waited);
        checkOutput("r0NoStall", waited, 32'd0);

        exe_waddr = 7; exe_wdata = 32'h7777_0000;
        applyStimulus("unusedNoStall", 32'h114, 5'd0, 5'd7, 1, 0, 32'hDEAD0006,
                      32'd0, 32'h7777_0000, waited);
        checkOutput("unusedWait", waited, 32'd0);
        clearBypass();

        // Load-use: stalled one cycle, then the load result arrives from mem.
        driveInstr(32'h200, 5'd0, 5'd7, 0, 1, 32'hBEEF0001);
        nextCycle();
        in_valid = 0;
        exe_valid = 1; exe_we = 1; exe_is_load = 1; exe_waddr = 7; exe_wdata = 32'hBAD0_BAD0;
        pushExpected(32'h200, 32'd0, 32'h1234, 32'hBEEF0001);
        #4;
        checkOutput("loadUseValid",   {31'd0, out_valid}, 32'd0);
        checkOutput("loadUseAllowin", {31'd0, in_allowin}, 32'd0);
        checkOutput("loadUseRaddr2",  {27'd0, raddr2}, 32'd7);
        nextCycle();
        clearBypass();
        mem_valid = 1; mem_we = 1; mem_ready = 1; mem_waddr = 7; mem_wdata = 32'h1234;
        popCompare("loadUseDone", waited);
        checkOutput("loadUseWait", waited, 32'd0);
        nextCycle();

        mem_ready = 0;
        driveInstr(32'h204, 5'd7, 5'd0, 1, 0, 32'hBEEF0002);
        nextCycle();
        in_valid = 0;
        #4;
        checkOutput("memBusyValid", {31'd0, out_valid}, 32'd0);
        nextCycle();
        mem_ready = 1;
        pushExpected(32'h204, 32'h1234, 32'd0, 32'hBEEF0002);
        popCompare("memBusyDone", waited);
        nextCycle();
        clearBypass();

        // Back-pressure for three cycles, with a competing offer that must wait.
        driveInstr(32'h300, 5'd5, 5'd0, 1, 0, 32'hCAFE0001);
        nextCycle();
        out_allowin = 0;
        driveInstr(32'h399, 5'd3, 5'd0, 1, 0, 32'hCAFE0002);
        for (int i = 0; i < 3; i++) begin
            #4;
            checkOutput("bpValid",   {31'd0, out_valid}, 32'd1);
            checkOutput("bpPc",      out_pc, 32'h300);
            checkOutput("bpSrc1",    out_src1, 32'h1111_1111);
            checkOutput("bpAllowin", {31'd0, in_allowin}, 32'd0);
            nextCycle();
        end
        flush = 1; out_allowin = 1;
        #4;
        checkOutput("flushOutValid", {31'd0, out_valid}, 32'd0);
        nextCycle();
        flush = 0; in_valid = 0;
        #4;
        checkOutput("flushGone",    {31'd0, out_valid}, 32'd0);
        checkOutput("flushAllowin", {31'd0, in_allowin}, 32'd1);
        nextCycle();
        applyStimulus("afterFlush", 32'h400, 5'd5, 5'd0, 1, 0, 32'hCAFE0003,
                      32'h1111_1111, 32'd0, waited);

        // Reset arriving while stalled discards the instruction.
        exe_valid = 1; exe_we = 1; exe_is_load = 1; exe_waddr = 9;
        driveInstr(32'h500, 5'd9, 5'd0, 1, 0, 32'hF00D0001);
        nextCycle();
        in_valid = 0;
        reset = 1;
        #4;
        checkOutput("rstStallValid", {31'd0, out_valid}, 32'd0);
        nextCycle();
        reset = 0;
        clearBypass();
        #4;
        checkOutput("rstStallGone",    {31'd0, out_valid}, 32'd0);
        checkOutput("rstStallPc",      out_pc, 32'd0);
        checkOutput("rstStallAllowin", {31'd0, in_allowin}, 32'd1);
        nextCycle();

        checkOutput("sbEmpty", scoreboard.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
